// File: rtl/i2c_target_rx.sv
// i2c_target_rx
// Write-only I2C target receiver. Oversamples the raw SCL/SDA pins with the
// system clock, decodes START/STOP, matches a 7-bit address with R/W = 0,
// ACKs the address and every accepted data byte, and hands each data byte
// to a consumer through a ready/valid style pulse. Reads are never ACKed.
//
// Ports
//   clk       system clock, all logic on its rising edge
//   reset_n   asynchronous active-low reset
//   scl_in    raw bus SCL (asynchronous to clk)
//   sda_in    raw bus SDA (asynchronous to clk)
//   sda_oe    1 = pull SDA low (open-drain), 0 = release
//   rx_ready  consumer can accept a byte
//   rx_data   last accepted data byte
//   rx_valid  one-clk pulse, rx_data newly valid
//   overrun   one-clk pulse, byte dropped because rx_ready was 0
//   busy      1 while addressed (ADDR_ACK, DATA, DATA_ACK)
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h27
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  // Two synchronizer flops plus one delay flop per pin; all reset to 1 so
  // the bus looks idle and no edge is flagged coming out of reset.
  logic scl_meta_reg, scl_sync_reg, scl_dly_reg;
  logic sda_meta_reg, sda_sync_reg, sda_dly_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_meta_reg <= 1'b1;
      scl_sync_reg <= 1'b1;
      scl_dly_reg  <= 1'b1;
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
      sda_dly_reg  <= 1'b1;
    end else begin
      scl_meta_reg <= scl_in;
      scl_sync_reg <= scl_meta_reg;
      scl_dly_reg  <= scl_sync_reg;
      sda_meta_reg <= sda_in;
      sda_sync_reg <= sda_meta_reg;
      sda_dly_reg  <= sda_sync_reg;
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  assign scl_rise  = scl_sync_reg & ~scl_dly_reg;
  assign scl_fall  = ~scl_sync_reg & scl_dly_reg;
  assign sda_rise  = sda_sync_reg & ~sda_dly_reg;
  assign sda_fall  = ~sda_sync_reg & sda_dly_reg;
  // SDA may only change while SCL is low; an SDA edge with SCL high is a
  // bus condition, never data.
  assign start_det = sda_fall & scl_sync_reg;
  assign stop_det  = sda_rise & scl_sync_reg;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        done_reg, done_next;      // 8 bits shifted, waiting for SCL fall
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        rx_valid_reg, rx_valid_next;
  logic        overrun_reg, overrun_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      shift_reg    <= 8'h00;
      done_reg     <= 1'b0;
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shift_reg    <= shift_next;
      done_reg     <= done_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      overrun_reg  <= overrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    done_next     = done_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    overrun_next  = 1'b0;

    // START wins over any SCL edge flagged in the same clk.
    if (start_det) begin
      state_next = ADDR;
      cnt_next   = 3'd0;
      shift_next = 8'h00;
      done_next  = 1'b0;
    end else if (stop_det) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        ADDR, DATA: begin
          if (scl_rise && !done_reg) begin
            shift_next = {shift_reg[6:0], sda_sync_reg};
            cnt_next   = cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
              done_next = 1'b1;
            end
          end else if (scl_fall && done_reg) begin
            // SCL fall ending bit 8: decide ACK/NACK for the 9th bit.
            done_next = 1'b0;
            cnt_next  = 3'd0;
            if (state_reg == ADDR) begin
              if ((shift_reg[7:1] == TARGET_ADDR) && !shift_reg[0]) begin
                state_next = ADDR_ACK;
              end else begin
                state_next = IGNORE;
              end
            end else if (rx_ready) begin
              rx_data_next  = shift_reg;
              rx_valid_next = 1'b1;
              state_next    = DATA_ACK;
            end else begin
              overrun_next = 1'b1;
              state_next   = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // The SCL fall ending the ACK bit releases SDA.
          if (scl_fall) begin
            state_next = DATA;
            cnt_next   = 3'd0;
            shift_next = 8'h00;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Derived from the state register so that reset releases SDA at once;
  // the STOP mask releases it in the same clk the STOP is seen.
  assign sda_oe   = ((state_reg == ADDR_ACK) || (state_reg == DATA_ACK)) && !stop_det;
  assign busy     = (state_reg == ADDR_ACK) || (state_reg == DATA) || (state_reg == DATA_ACK);
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Testbench for i2c_target_rx: an I2C master model drives SCL/SDA over an
// open-drain SDA line; expected data bytes go into a scoreboard queue when
// they are sent and are popped whenever the DUT pulses rx_valid.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       rx_ready = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, rx_valid, overrun, busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  i2c_target_rx #(.TARGET_ADDR(7'h27)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .overrun  (overrun),
    .busy     (busy)
  );

  int tests = 0;
  int fails = 0;
  int q_ns = 250;        // quarter SCL period: 25 clk -> 1 MHz bus
  int valid_cnt = 0;
  int ovr_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("rx_valid_unexpected", 32'd1, 32'd0);
      end else begin
        check("sb_rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (overrun) ovr_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clr_counts();
    valid_cnt = 0;
    ovr_cnt   = 0;
    oe_cnt    = 0;
    busy_cnt  = 0;
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; #(q_ns);
    scl_drv = 1'b1; #(q_ns);
    sda_drv = 1'b0; #(q_ns);
    scl_drv = 1'b0; #(q_ns);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; #(q_ns);
    scl_drv = 1'b1; #(q_ns);
    sda_drv = 1'b1; #(2 * q_ns);
  endtask

  task automatic send8(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; #(q_ns);
      scl_drv = 1'b1; #(2 * q_ns);
      scl_drv = 1'b0; #(q_ns);
    end
  endtask

  task automatic ack_slot(output logic acked);
    sda_drv = 1'b1; #(q_ns);
    scl_drv = 1'b1; #(q_ns);
    acked = (sda_in == 1'b0);
    #(q_ns);
    scl_drv = 1'b0; #(q_ns);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    send8(b);
    ack_slot(acked);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       ready;
    logic       exp_aack;
    logic       exp_dack;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic a, d;
    logic seen;

    vecs[0] = '{8'h4E, 8'hA5, 1'b1, 1'b1, 1'b1};  // 0x27+W, accepted
    vecs[1] = '{8'h50, 8'hFF, 1'b1, 1'b0, 1'b0};  // 0x28+W, not us
    vecs[2] = '{8'h4E, 8'h00, 1'b1, 1'b1, 1'b1};  // all-zero byte
    vecs[3] = '{8'h4E, 8'h81, 1'b0, 1'b1, 1'b0};  // consumer not ready
    vecs[4] = '{8'h4C, 8'h3C, 1'b1, 1'b0, 1'b0};  // 0x26+W, not us

    // Reset state
    #103;
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    #100;

    // 100 kHz write of 0x5A
    q_ns = 2500;
    clr_counts();
    bus_start();
    write_byte(8'h4E, a);
    check("slow_addr_ack", {31'd0, a}, 32'd1);
    check("slow_busy_mid", {31'd0, busy}, 32'd1);
    exp_q.push_back(8'h5A);
    model_data = 8'h5A;
    write_byte(8'h5A, d);
    check("slow_data_ack", {31'd0, d}, 32'd1);
    bus_stop();
    repeat (10) @(negedge clk);
    check("slow_rx_data", {24'd0, rx_data}, {24'd0, model_data});
    check("slow_valid_cnt", valid_cnt, 32'd1);
    check("slow_busy_after_stop", {31'd0, busy}, 32'd0);
    q_ns = 250;

    // Table-driven single-byte writes
    for (int k = 0; k < 5; k++) begin
      clr_counts();
      rx_ready = 1'b1;
      bus_start();
      write_byte(vecs[k].addr, a);
      check("tbl_addr_ack", {31'd0, a}, {31'd0, vecs[k].exp_aack});
      rx_ready = vecs[k].ready;
      if (vecs[k].exp_dack) begin
        exp_q.push_back(vecs[k].data);
        model_data = vecs[k].data;
      end
      write_byte(vecs[k].data, d);
      check("tbl_data_ack", {31'd0, d}, {31'd0, vecs[k].exp_dack});
      bus_stop();
      rx_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("tbl_valid_cnt", valid_cnt, {31'd0, vecs[k].exp_dack});
      check("tbl_overrun_cnt", ovr_cnt, {31'd0, vecs[k].exp_aack & ~vecs[k].ready});
      check("tbl_rx_data", {24'd0, rx_data}, {24'd0, model_data});
      check("tbl_busy_end", {31'd0, busy}, 32'd0);
      check("tbl_queue_empty", exp_q.size(), 32'd0);
      if (!vecs[k].exp_aack) begin
        check("tbl_oe_never", oe_cnt, 32'd0);
        check("tbl_busy_never", busy_cnt, 32'd0);
      end
    end

    // Read request: NACKed, ignored until STOP
    clr_counts();
    bus_start();
    write_byte(8'h4F, a);
    check("read_addr_ack", {31'd0, a}, 32'd0);
    check("read_busy", {31'd0, busy}, 32'd0);
    write_byte(8'hFF, d);
    check("read_oe_before_stop", oe_cnt, 32'd0);
    bus_stop();
    repeat (10) @(negedge clk);
    check("read_oe_total", oe_cnt, 32'd0);
    check("read_valid_cnt", valid_cnt, 32'd0);

    // Two bytes, second one overruns
    clr_counts();
    bus_start();
    write_byte(8'h4E, a);
    check("ovr_addr_ack", {31'd0, a}, 32'd1);
    rx_ready = 1'b1;
    exp_q.push_back(8'h11);
    model_data = 8'h11;
    write_byte(8'h11, d);
    check("ovr_byte1_ack", {31'd0, d}, 32'd1);
    rx_ready = 1'b0;
    write_byte(8'h22, d);
    check("ovr_byte2_nack", {31'd0, d}, 32'd0);
    bus_stop();
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("ovr_rx_data", {24'd0, rx_data}, {24'd0, model_data});
    check("ovr_valid_cnt", valid_cnt, 32'd1);
    check("ovr_overrun_cnt", ovr_cnt, 32'd1);

    // Repeated START
    clr_counts();
    bus_start();
    write_byte(8'h4E, a);
    exp_q.push_back(8'h33);
    write_byte(8'h33, d);
    check("rs_byte1_ack", {31'd0, d}, 32'd1);
    bus_start();
    write_byte(8'h4E, a);
    check("rs_addr2_ack", {31'd0, a}, 32'd1);
    exp_q.push_back(8'h44);
    model_data = 8'h44;
    write_byte(8'h44, d);
    check("rs_byte2_ack", {31'd0, d}, 32'd1);
    bus_stop();
    repeat (10) @(negedge clk);
    check("rs_valid_cnt", valid_cnt, 32'd2);
    check("rs_rx_data", {24'd0, rx_data}, {24'd0, model_data});
    check("rs_queue_empty", exp_q.size(), 32'd0);

    // Reset during the address ACK window
    clr_counts();
    bus_start();
    send8(8'h4E);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = sda_oe;
    end
    check("rstack_oe_before", {31'd0, seen}, 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("rstack_oe_async", {31'd0, sda_oe}, 32'd0);
    #20;
    check("rstack_busy", {31'd0, busy}, 32'd0);
    check("rstack_rx_data", {24'd0, rx_data}, 32'd0);
    model_data = 8'h00;
    @(negedge clk);
    #2 reset_n = 1'b1;
    scl_drv = 1'b1; #(2 * q_ns);
    check("rstack_oe_released", {31'd0, sda_oe}, 32'd0);
    scl_drv = 1'b0; #(q_ns);
    bus_stop();
    clr_counts();
    bus_start();
    write_byte(8'h4E, a);
    check("rstack_addr_ack", {31'd0, a}, 32'd1);
    exp_q.push_back(8'h66);
    model_data = 8'h66;
    write_byte(8'h66, d);
    check("rstack_data_ack", {31'd0, d}, 32'd1);
    bus_stop();
    repeat (10) @(negedge clk);
    check("rstack_rx_data_after", {24'd0, rx_data}, {24'd0, model_data});
    check("rstack_valid_cnt", valid_cnt, 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h27, meaning the 7-bit address this target answers.
REQ-002 SHALL have port clk, input, 1 bit: system clock (100 MHz), all logic on posedge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port scl_in, input, 1 bit: raw bus SCL, asynchronous to clk.
REQ-005 SHALL have port sda_in, input, 1 bit: raw bus SDA, asynchronous to clk.
REQ-006 SHALL have port sda_oe, output, 1 bit: 1 = pull SDA low (open-drain); 0 = release.
REQ-007 SHALL have port rx_ready, input, 1 bit: consumer can accept a byte.
REQ-008 SHALL have port rx_data, output, 8 bits: last received data byte.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-clk pulse, rx_data newly valid.
REQ-010 SHALL have port overrun, output, 1 bit: one-clk pulse, byte dropped because rx_ready was 0.
REQ-011 SHALL have port busy, output, 1 bit: 1 from START to STOP while addressed.

Function
REQ-012 SHALL pass scl_in and sda_in each through a 2-flop synchronizer plus one delay flop; rise/fall flags = sync & ~delay / ~sync & delay, valid 3 clk after a pin change is first sampled.
REQ-013 SHALL detect START as SDA fall while synchronized SCL = 1, and STOP as SDA rise while synchronized SCL = 1; both checked in every state.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 SHALL go to ADDR from any state on START (repeated START included), clearing the bit counter and shift register.
REQ-016 SHALL, in ADDR and DATA, shift synchronized SDA MSB-first on each SCL rise, 3-bit counter 0..7, 9th bit being ACK slot.
REQ-017 SHALL, after 8th address bit (7 addr + R/W): if addr == TARGET_ADDR and R/W = 0, go ADDR_ACK; otherwise go IGNORE (reads always NACKed).
REQ-018 SHALL assert sda_oe on the SCL fall ending bit 8 and deassert it on the next SCL fall; ADDR_ACK then goes to DATA.
REQ-019 SHALL, after 8th data bit, sample rx_ready on the SCL fall ending bit 8: if 1, load rx_data, pulse rx_valid one clk, drive ACK per REQ-018, go DATA_ACK; if 0, leave rx_data unchanged, pulse overrun, release SDA (NACK), go IGNORE.
REQ-020 SHALL return DATA_ACK to DATA on the SCL fall releasing ACK, counter reset to 0.
REQ-021 SHALL, in IGNORE, keep sda_oe = 0 and wait for START or STOP.
REQ-022 SHALL go to IDLE on STOP from any state, deasserting sda_oe in the same clk.
REQ-023 SHALL hold busy = 1 in ADDR_ACK, DATA, DATA_ACK; 0 otherwise.
REQ-024 SHALL never assert sda_oe outside ADDR_ACK/DATA_ACK ACK windows.
REQ-025 SHALL ignore SCL edges in IDLE; SDA changes with SCL = 1 mid-byte are START/STOP, not data.
REQ-026 SHALL give START priority if START and an SCL edge are flagged in the same clk; the SCL edge is discarded.

Reset
REQ-027 SHALL, while reset_n = 0, force state IDLE, sda_oe 0, rx_data 8'h00, rx_valid 0, overrun 0, busy 0, synchronizer flops 1 (idle bus).
REQ-028 SHALL, on reset_n assertion mid-transfer, release SDA immediately (asynchronously) and, after release, ignore the bus until the next START.

Verification
REQ-029 Bench SHALL check: START, addr 0x27+W, byte 0x5A, STOP at 100 kHz, rx_ready = 1 -> ACK on both 9th bits, rx_data = 0x5A, one rx_valid pulse, busy 0 after STOP.
REQ-030 Bench SHALL check: START, addr 0x28+W, byte 0xFF -> sda_oe never 1, no rx_valid, busy stays 0.
REQ-031 Bench SHALL check: START, addr 0x27+R -> NACK, state IGNORE, sda_oe 0 until STOP.
REQ-032 Bench SHALL check: addr 0x27+W then 0x11 (rx_ready = 1), 0x22 (rx_ready = 0) -> rx_data = 0x11, one rx_valid, one overrun pulse, NACK on byte 2.
REQ-033 Bench SHALL check: 0x27+W, 0x33, repeated START, 0x27+W, 0x44, STOP -> two rx_valid pulses, values 0x33 then 0x44.
REQ-034 Bench SHALL check: reset_n low during ACK window of 0x27 -> sda_oe 0 same cycle; next full write 0x27+W, 0x66 -> rx_data = 0x66.
